// File: rtl/hs_tx_stream_pkg.sv
// Shared state type and default parameters for the hs_tx_stream request/ack source.
package hs_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_REQ   = 2'd2,
    ST_GAP   = 2'd3
  } hs_tx_state_t;

  localparam int HS_DW      = 4;
  localparam int HS_DEPTH   = 4;
  localparam int HS_GAP     = 4;
  localparam int HS_TIMEOUT = 64;
endpackage

// File: rtl/hs_tx_stream_sync_3ff.sv
// Three-flop synchronizer for the clk_b ack level; s2/s3 exposed for edge detection.
module hs_sync_3ff (
  input  logic clk_a,
  input  logic rst_n,
  input  logic d,
  output logic s2,
  output logic s3
);
  logic s1_q, s2_q, s3_q;

  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= d;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign s2 = s2_q;
  assign s3 = s3_q;
endmodule

// File: rtl/hs_tx_stream.sv
// Source side of the clk_a->clk_b req/ack crossing: FIFO, hold-stable data bus, level data_req.
// Optional REQ timeout/retry enabled by defining HS_TX_STREAM_TIMEOUT_EN.
module hs_tx_stream
  import hs_pkg::*;
#(
  parameter int DW      = HS_DW,
  parameter int DEPTH   = HS_DEPTH,
  parameter int GAP     = HS_GAP,
  parameter int TIMEOUT = HS_TIMEOUT
) (
  input  logic                     clk_a,
  input  logic                     rst_n,
  input  logic                     in_valid,
  input  logic [DW-1:0]            in_data,
  output logic                     in_ready,
  input  logic                     data_ack,
  output logic [DW-1:0]            data,
  output logic                     data_req,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     busy,
  output logic                     timeout_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP - 1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q;
  logic          fifo_empty, fifo_full, push;

  hs_tx_state_t  state_q;
  logic [DW-1:0] data_q;
  logic          data_req_q;
  logic [GW-1:0] gap_cnt_q;
  logic          ack_s2, ack_s3, ack_rise;

  // Extra wrap bit distinguishes full from empty when the indexes coincide.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign fifo_level = wr_ptr_q - rd_ptr_q;
  assign in_ready   = !fifo_full;
  assign push       = in_valid && !fifo_full;
  assign wr_ptr_d   = push ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;

  always_ff @(posedge clk_a) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
    end
  end

  hs_sync_3ff u_ack_sync (
    .clk_a (clk_a),
    .rst_n (rst_n),
    .d     (data_ack),
    .s2    (ack_s2),
    .s3    (ack_s3)
  );

  assign ack_rise = ack_s2 & ~ack_s3;

`ifdef HS_TX_STREAM_TIMEOUT_EN
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  logic [TW-1:0] tmo_cnt_q;
  logic          retry_q;
  logic          timeout_err_q;
  assign timeout_err = timeout_err_q;
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk_a or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      data_q     <= '0;
      data_req_q <= 1'b0;
      gap_cnt_q  <= '0;
      rd_ptr_q   <= '0;
`ifdef HS_TX_STREAM_TIMEOUT_EN
      tmo_cnt_q     <= '0;
      retry_q       <= 1'b0;
      timeout_err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          // The only point where the data bus is allowed to change.
          if (!fifo_empty) begin
            data_q   <= mem_q[rd_ptr_q[AW-1:0]];
            rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
            state_q  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          data_req_q <= 1'b1;
          state_q    <= ST_REQ;
`ifdef HS_TX_STREAM_TIMEOUT_EN
          tmo_cnt_q  <= '0;
`endif
        end
        ST_REQ: begin
          if (ack_rise) begin
            data_req_q <= 1'b0;
            gap_cnt_q  <= GAP_LOAD;
            state_q    <= ST_GAP;
`ifdef HS_TX_STREAM_TIMEOUT_EN
            retry_q    <= 1'b0;
          end else if (tmo_cnt_q == TMO_LAST) begin
            data_req_q    <= 1'b0;
            gap_cnt_q     <= GAP_LOAD;
            state_q       <= ST_GAP;
            retry_q       <= 1'b1;
            timeout_err_q <= 1'b1;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TW'(1);
`endif
          end
        end
        ST_GAP: begin
          if (gap_cnt_q == '0) begin
`ifdef HS_TX_STREAM_TIMEOUT_EN
            // A timed-out word is re-requested without popping a new one.
            if (retry_q) begin
              retry_q <= 1'b0;
              state_q <= ST_SETUP;
            end else begin
              state_q <= ST_IDLE;
            end
`else
            state_q <= ST_IDLE;
`endif
          end else begin
            gap_cnt_q <= gap_cnt_q - GW'(1);
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign data     = data_q;
  assign data_req = data_req_q;
  assign busy     = (state_q != ST_IDLE) || !fifo_empty;
endmodule

// File: tb/tb_hs_tx_stream.sv
// Directed scoreboard bench for hs_tx_stream; timeout steps depend on HS_TX_STREAM_TIMEOUT_EN.
module tb_hs_tx_stream;
  localparam int DW = 4;
  localparam int DEPTH = 4;
  localparam int GAP_C = 4;
  localparam int TMO_C = 8;

  logic          clk_a = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          data_ack = 1'b0;
  logic [DW-1:0] data;
  logic          data_req;
  logic [2:0]    fifo_level;
  logic          busy;
  logic          timeout_err;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb [$];

  hs_tx_stream #(.DW(DW), .DEPTH(DEPTH), .GAP(GAP_C), .TIMEOUT(TMO_C)) dut (
    .clk_a       (clk_a),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .data_ack    (data_ack),
    .data        (data),
    .data_req    (data_req),
    .fifo_level  (fifo_level),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk_a = ~clk_a;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_a);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    if (in_ready) begin
      sb.push_back(w);
      $display("push data=%h level=%0d", w, fifo_level);
    end else begin
      $display("push data=%h refused", w);
    end
    tick(1);
    in_valid = 1'b0;
  endtask

  // Receiver model: wait for the request, return a 3-cycle ack pulse, wait for the drop.
  task automatic serve_one(input string tag);
    int k;
    k = 0;
    while (!data_req && k < 100) begin
      tick(1);
      k++;
    end
    check({tag, "_req_seen"}, 32'(data_req), 32'd1);
    tick(2);
    data_ack = 1'b1;
    tick(3);
    data_ack = 1'b0;
    k = 0;
    while (data_req && k < 20) begin
      tick(1);
      k++;
    end
    check({tag, "_req_dropped"}, 32'(data_req), 32'd0);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    k = 0;
    while (busy && k < 300) begin
      tick(1);
      k++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  // Monitor: every request rise is scored; a drop without ack means a retry of the same word.
  logic          prev_req = 1'b0;
  logic          acked = 1'b0;
  logic          retry_pend = 1'b0;
  logic          have_fell = 1'b0;
  int            low_cnt = 0;
  int            min_low;
  logic [DW-1:0] last_word = '0;
  logic [DW-1:0] exp_word;

  always @(negedge clk_a) begin
    if (!rst_n) begin
      prev_req   = 1'b0;
      acked      = 1'b0;
      retry_pend = 1'b0;
      have_fell  = 1'b0;
      low_cnt    = 0;
    end else begin
      if (data_req && !prev_req) begin
        if (have_fell) begin
          min_low = retry_pend ? GAP_C + 1 : GAP_C + 2;
          check("gap_low_time_ok", 32'(low_cnt >= min_low), 32'd1);
        end
        if (retry_pend) begin
          check("retry_data", 32'(data), 32'(last_word));
          $display("req retry data=%h", data);
        end else begin
          checks++;
          assert (sb.size() != 0) else begin
            errors++;
            $error("FAIL unexpected_req: observed data=%h expected no request", data);
          end
          if (sb.size() != 0) begin
            exp_word = sb.pop_front();
            check("req_data", 32'(data), 32'(exp_word));
            last_word = exp_word;
            $display("req data=%h expected=%h", data, exp_word);
          end
        end
        acked      = 1'b0;
        retry_pend = 1'b0;
      end
      if (data_req && prev_req) begin
        check("data_stable", 32'(data), 32'(last_word));
      end
      if (data_req && data_ack) acked = 1'b1;
      if (!data_req && prev_req) begin
`ifndef HS_TX_STREAM_TIMEOUT_EN
        check("drop_after_ack", 32'(acked), 32'd1);
`endif
        have_fell  = 1'b1;
        low_cnt    = 0;
        retry_pend = !acked;
        $display("req drop data=%h acked=%0d", data, acked);
      end
      if (!data_req) low_cnt++;
      prev_req = data_req;
    end
  end

  initial begin
    int accepted;
    // Reset state
    tick(3);
    check("rst_data_req", 32'(data_req), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    tick(2);

    // Single word: push at T, ack raised right after T+2
    push_word(4'h3);
    check("t1_level_after_T", 32'(fifo_level), 32'd1);
    check("t1_req_after_T", 32'(data_req), 32'd0);
    tick(1);
    check("t1_data_after_T1", 32'(data), 32'h3);
    check("t1_req_after_T1", 32'(data_req), 32'd0);
    check("t1_level_after_T1", 32'(fifo_level), 32'd0);
    tick(1);
    check("t1_req_after_T2", 32'(data_req), 32'd1);
    data_ack = 1'b1;
    tick(2);
    check("t1_req_after_A1", 32'(data_req), 32'd1);
    tick(1);
    check("t1_req_after_A2", 32'(data_req), 32'd0);
    data_ack = 1'b0;
    tick(3);
    check("t1_busy_in_gap", 32'(busy), 32'd1);
    tick(1);
    check("t1_busy_after_gap", 32'(busy), 32'd0);
    check("t1_data_held", 32'(data), 32'h3);

    // Burst 1..6 without ack
    accepted = 0;
    in_valid = 1'b1;
    for (int w = 1; w <= 6; w++) begin
      in_data = 4'(w);
      if (in_ready) begin
        sb.push_back(4'(w));
        accepted++;
        $display("push data=%h level=%0d", in_data, fifo_level);
      end else begin
        $display("push data=%h refused", in_data);
      end
      tick(1);
    end
    in_valid = 1'b0;
    check("burst_accepted", 32'(accepted), 32'd5);
    check("burst_level_full", 32'(fifo_level), 32'd4);
    check("burst_in_ready_low", 32'(in_ready), 32'd0);
    check("burst_data_head", 32'(data), 32'h1);
    tick(10);
    check("burst_data_still_head", 32'(data), 32'h1);
    check("burst_level_still_full", 32'(fifo_level), 32'd4);

    // Drain the burst with the receiver model; order checked by the monitor
    for (int i = 0; i < 5; i++) serve_one("drain");
    wait_idle("drain_idle");
    check("drain_sb_empty", 32'(sb.size()), 32'd0);
    check("drain_level", 32'(fifo_level), 32'd0);
    check("drain_in_ready", 32'(in_ready), 32'd1);

    // Stray ack during GAP
    push_word(4'hA);
    push_word(4'hB);
    serve_one("stray_a");
    tick(1);
    data_ack = 1'b1;
    tick(3);
    data_ack = 1'b0;
    check("stray_data_kept", 32'(data), 32'hA);
    check("stray_level_kept", 32'(fifo_level), 32'd1);
    check("stray_req_low", 32'(data_req), 32'd0);
    serve_one("stray_b");
    wait_idle("stray_idle");
    check("stray_data_b", 32'(data), 32'hB);

    // Long REQ without ack
    push_word(4'h9);
    tick(2);
    check("tmo_req_up", 32'(data_req), 32'd1);
    tick(7);
    check("tmo_req_R7", 32'(data_req), 32'd1);
    check("tmo_err_R7", 32'(timeout_err), 32'd0);
`ifdef HS_TX_STREAM_TIMEOUT_EN
    tick(1);
    check("tmo_req_dropped", 32'(data_req), 32'd0);
    check("tmo_err_set", 32'(timeout_err), 32'd1);
    check("tmo_data_kept", 32'(data), 32'h9);
    tick(4);
    check("tmo_req_low_before_retry", 32'(data_req), 32'd0);
    tick(1);
    check("tmo_req_retry", 32'(data_req), 32'd1);
    check("tmo_retry_data", 32'(data), 32'h9);
    serve_one("tmo_retry");
    wait_idle("tmo_idle");
    check("tmo_err_sticky", 32'(timeout_err), 32'd1);
`else
    tick(13);
    check("notmo_req_held", 32'(data_req), 32'd1);
    check("notmo_err_zero", 32'(timeout_err), 32'd0);
    check("notmo_data", 32'(data), 32'h9);
    serve_one("notmo");
    wait_idle("notmo_idle");
    check("notmo_err_after", 32'(timeout_err), 32'd0);
`endif

    // Reset mid-transfer with two words queued
    in_valid = 1'b1;
    for (int w = 12; w <= 14; w++) begin
      in_data = 4'(w);
      if (in_ready) begin
        sb.push_back(4'(w));
        $display("push data=%h level=%0d", in_data, fifo_level);
      end
      tick(1);
    end
    in_valid = 1'b0;
    check("rstx_req_high", 32'(data_req), 32'd1);
    check("rstx_level_two", 32'(fifo_level), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("rstx_req_async_drop", 32'(data_req), 32'd0);
    check("rstx_level", 32'(fifo_level), 32'd0);
    check("rstx_data", 32'(data), 32'd0);
    check("rstx_in_ready", 32'(in_ready), 32'd1);
    check("rstx_timeout_err", 32'(timeout_err), 32'd0);
    sb.delete();
    $display("reset mid-transfer, scoreboard flushed");
    tick(1);
    rst_n = 1'b1;
    tick(4);
    check("rstx_req_stays_low", 32'(data_req), 32'd0);
    check("rstx_busy", 32'(busy), 32'd0);
    check("rstx_level_after", 32'(fifo_level), 32'd0);
    check("final_sb_empty", 32'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
